// File: rtl/pc_chain_sequencer.sv
// Control sequencer for a program counter built from cascaded 4-bit loadable counter slices.
// Arbitrates jump loads against free-running increment and can halt at terminal count.
module pc_chain_sequencer #(
    parameter int WIDTH      = 16,
    parameter int RST_CYCLES = 2,
    parameter int WRAP       = 1
) (
    input  logic             CP,
    input  logic             _MR,
    input  logic             run,
    input  logic             stall,
    input  logic             jmp_req,
    input  logic [WIDTH-1:0] jmp_addr,
    output logic             jmp_ack,
    output logic             cnt_MR_n,
    output logic             cnt_PE_n,
    output logic             cnt_CEP,
    output logic             cnt_CET,
    output logic [WIDTH-1:0] cnt_D,
    input  logic [WIDTH-1:0] cnt_Q,
    input  logic             cnt_TC,
    output logic             halted,
    output logic [2:0]       state
);

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam int          CW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] INIT_LAST = CW'(RST_CYCLES - 1);
    localparam bit          HALT_AT_TC = (WRAP == 0);

    logic [2:0]       state_q, state_d, state_dec;
    logic [CW-1:0]    init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0] jreg_q, jreg_d;

    // The PC value itself is consumed by the control unit, not by the sequencer.
    logic unused_pc;
    assign unused_pc = ^cnt_Q;

    // Encodings 5..7 cannot be reached; treat them as INIT so the chain is held cleared.
    assign state_dec = (state_q > S_HALT) ? S_INIT : state_q;
    assign state     = state_dec;

    always_ff @(posedge CP) begin
        if (!_MR) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            jreg_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            jreg_q     <= jreg_d;
        end
    end

    always_comb begin
        state_d    = state_dec;
        init_cnt_d = init_cnt_q;
        jreg_d     = jreg_q;
        case (state_dec)
            S_IDLE: begin
                if (jmp_req) begin
                    jreg_d  = jmp_addr;
                    state_d = S_LOAD;
                end else if (run) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (jmp_req) begin
                    jreg_d  = jmp_addr;
                    state_d = S_LOAD;
                end else if (HALT_AT_TC && cnt_TC) begin
                    state_d = S_HALT;
                end else if (!run) begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: state_d = run ? S_RUN : S_IDLE;
            S_HALT: begin
                if (jmp_req) begin
                    jreg_d  = jmp_addr;
                    state_d = S_LOAD;
                end
            end
            default: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Controls are combinational so the chain acts on the same edge the FSM moves.
    always_comb begin
        cnt_MR_n = 1'b1;
        cnt_PE_n = 1'b1;
        cnt_CEP  = 1'b0;
        cnt_CET  = 1'b0;
        cnt_D    = '0;
        jmp_ack  = 1'b0;
        halted   = 1'b0;
        case (state_dec)
            S_IDLE: ;
            S_RUN: begin
                cnt_CET = 1'b1;
                cnt_CEP = run & ~stall & ~jmp_req & ~(HALT_AT_TC & cnt_TC);
            end
            S_LOAD: begin
                cnt_PE_n = 1'b0;
                cnt_D    = jreg_q;
                jmp_ack  = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: cnt_MR_n = 1'b0;
        endcase
        if (!_MR) begin
            cnt_MR_n = 1'b0;
            cnt_PE_n = 1'b1;
            cnt_CEP  = 1'b0;
            cnt_CET  = 1'b0;
            cnt_D    = '0;
            jmp_ack  = 1'b0;
            halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_chain_sequencer.sv
// Bench for pc_chain_sequencer: two instances (wrapping and halting) each driving a
// behavioural 4-bit-slice counter chain, checked against hand-computed vectors.
module tb_pc_chain_sequencer;

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    // Control bundle {MR_n, PE_n, CEP, CET, ack, halted}
    localparam logic [5:0] C_RST  = 6'b010000;
    localparam logic [5:0] C_IDLE = 6'b110000;
    localparam logic [5:0] C_RUN  = 6'b111100;
    localparam logic [5:0] C_RUNH = 6'b110100;
    localparam logic [5:0] C_LOAD = 6'b100010;
    localparam logic [5:0] C_HALT = 6'b110001;

    logic        CP = 1'b0;
    logic        mr_n = 1'b0, run = 1'b0, stall = 1'b0, jmp_req = 1'b0;
    logic [15:0] jmp_addr = 16'h0000;

    logic        ack_w, mrn_w, pen_w, cep_w, cet_w, halt_w, tc_w;
    logic [15:0] d_w, q_w;
    logic [2:0]  st_w;
    logic        ack_h, mrn_h, pen_h, cep_h, cet_h, halt_h, tc_h;
    logic [15:0] d_h, q_h;
    logic [2:0]  st_h;

    always #5 CP = ~CP;

    pc_chain_sequencer #(.WIDTH(16), .RST_CYCLES(2), .WRAP(1)) u_wrap (
        .CP(CP), ._MR(mr_n), .run(run), .stall(stall), .jmp_req(jmp_req), .jmp_addr(jmp_addr),
        .jmp_ack(ack_w), .cnt_MR_n(mrn_w), .cnt_PE_n(pen_w), .cnt_CEP(cep_w), .cnt_CET(cet_w),
        .cnt_D(d_w), .cnt_Q(q_w), .cnt_TC(tc_w), .halted(halt_w), .state(st_w)
    );

    pc_chain_sequencer #(.WIDTH(16), .RST_CYCLES(2), .WRAP(0)) u_halt (
        .CP(CP), ._MR(mr_n), .run(run), .stall(stall), .jmp_req(jmp_req), .jmp_addr(jmp_addr),
        .jmp_ack(ack_h), .cnt_MR_n(mrn_h), .cnt_PE_n(pen_h), .cnt_CEP(cep_h), .cnt_CET(cet_h),
        .cnt_D(d_h), .cnt_Q(q_h), .cnt_TC(tc_h), .halted(halt_h), .state(st_h)
    );

    // Counter chain: synchronous clear over load over count, TC of the top slice.
    always @(posedge CP) begin
        if (!mrn_w)             q_w <= 16'h0000;
        else if (!pen_w)        q_w <= d_w;
        else if (cep_w && cet_w) q_w <= q_w + 16'h0001;
    end
    assign tc_w = cet_w & (&q_w);

    always @(posedge CP) begin
        if (!mrn_h)             q_h <= 16'h0000;
        else if (!pen_h)        q_h <= d_h;
        else if (cep_h && cet_h) q_h <= q_h + 16'h0001;
    end
    assign tc_h = cet_h & (&q_h);

    typedef struct {
        bit          mr, run, stall, jreq;
        logic [15:0] addr;
        bit          chk_sq;
        logic [2:0]  e_st_w;
        logic [15:0] e_q_w;
        logic [5:0]  e_ctl_w;
        logic [2:0]  e_st_h;
        logic [15:0] e_q_h;
        logic [5:0]  e_ctl_h;
        logic [15:0] e_d;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[25];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input bit mr, input bit rn, input bit st, input bit jr,
                                input logic [15:0] addr, input bit chk,
                                input logic [2:0] sw, input logic [15:0] qw, input logic [5:0] cw,
                                input logic [2:0] sh, input logic [15:0] qh, input logic [5:0] ch,
                                input logic [15:0] d);
        vec_t v;
        v.mr = mr; v.run = rn; v.stall = st; v.jreq = jr; v.addr = addr; v.chk_sq = chk;
        v.e_st_w = sw; v.e_q_w = qw; v.e_ctl_w = cw;
        v.e_st_h = sh; v.e_q_h = qh; v.e_ctl_h = ch;
        v.e_d = d;
        return v;
    endfunction

    function automatic vec_t mks(input bit mr, input bit rn, input bit st, input bit jr,
                                 input logic [15:0] addr, input bit chk,
                                 input logic [2:0] s, input logic [15:0] q, input logic [5:0] c,
                                 input logic [15:0] d);
        return mk(mr, rn, st, jr, addr, chk, s, q, c, s, q, c, d);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(posedge CP);
        #1;
        mr_n = v.mr; run = v.run; stall = v.stall; jmp_req = v.jreq; jmp_addr = v.addr;
        sb_q.push_back(v);
        @(negedge CP);
        e = sb_q.pop_front();
        chk("ctl_w", idx, {10'd0, mrn_w, pen_w, cep_w, cet_w, ack_w, halt_w}, {10'd0, e.e_ctl_w});
        chk("ctl_h", idx, {10'd0, mrn_h, pen_h, cep_h, cet_h, ack_h, halt_h}, {10'd0, e.e_ctl_h});
        if (e.chk_sq) begin
            chk("state_w", idx, {13'd0, st_w}, {13'd0, e.e_st_w});
            chk("pc_w", idx, q_w, e.e_q_w);
            chk("state_h", idx, {13'd0, st_h}, {13'd0, e.e_st_h});
            chk("pc_h", idx, q_h, e.e_q_h);
        end
        if (!e.e_ctl_w[4] || !e.mr) chk("d_w", idx, d_w, e.e_d);
        if (!e.e_ctl_h[4] || !e.mr) chk("d_h", idx, d_h, e.e_d);
        $display("vec %0d: mr=%0d run=%0d stall=%0d jreq=%0d addr=%h | st=%0d/%0d pc=%h/%h ack=%0d/%0d",
                 idx, e.mr, e.run, e.stall, e.jreq, e.addr, st_w, st_h, q_w, q_h, ack_w, ack_h);
    endtask

    initial begin
        // Reset, INIT hold, count, stall, drop run, jumps from IDLE and RUN
        tbl[0]  = mks(0, 1, 0, 0, 16'h0000, 0, S_INIT, 16'h0000, C_RST, 16'h0000);
        tbl[1]  = mks(1, 1, 0, 0, 16'h0000, 1, S_INIT, 16'h0000, C_RST, 16'h0000);
        tbl[2]  = mks(1, 1, 0, 0, 16'h0000, 1, S_INIT, 16'h0000, C_RST, 16'h0000);
        tbl[3]  = mks(1, 1, 0, 0, 16'h0000, 1, S_IDLE, 16'h0000, C_IDLE, 16'h0000);
        for (int k = 4; k <= 8; k++)
            tbl[k] = mks(1, 1, 0, 0, 16'h0000, 1, S_RUN, 16'(k - 4), C_RUN, 16'h0000);
        for (int k = 9; k <= 11; k++)
            tbl[k] = mks(1, 1, 1, 0, 16'h0000, 1, S_RUN, 16'h0005, C_RUNH, 16'h0000);
        tbl[12] = mks(1, 1, 0, 0, 16'h0000, 1, S_RUN,  16'h0005, C_RUN,  16'h0000);
        tbl[13] = mks(1, 1, 0, 0, 16'h0000, 1, S_RUN,  16'h0006, C_RUN,  16'h0000);
        tbl[14] = mks(1, 0, 0, 0, 16'h0000, 1, S_RUN,  16'h0007, C_RUNH, 16'h0000);
        tbl[15] = mks(1, 0, 0, 0, 16'h0000, 1, S_IDLE, 16'h0007, C_IDLE, 16'h0000);
        tbl[16] = mks(1, 1, 0, 1, 16'h0010, 1, S_IDLE, 16'h0007, C_IDLE, 16'h0000);
        tbl[17] = mks(1, 1, 0, 0, 16'h0000, 1, S_LOAD, 16'h0007, C_LOAD, 16'h0010);
        tbl[18] = mks(1, 1, 0, 1, 16'h1234, 1, S_RUN,  16'h0010, C_RUNH, 16'h0000);
        tbl[19] = mks(1, 1, 0, 0, 16'hAAAA, 1, S_LOAD, 16'h0010, C_LOAD, 16'h1234);
        tbl[20] = mks(1, 1, 0, 0, 16'h0000, 1, S_RUN,  16'h1234, C_RUN,  16'h0000);
        tbl[21] = mks(1, 1, 0, 0, 16'h0000, 1, S_RUN,  16'h1235, C_RUN,  16'h0000);
        tbl[22] = mks(1, 0, 0, 1, 16'h5555, 1, S_RUN,  16'h1236, C_RUNH, 16'h0000);
        tbl[23] = mks(1, 0, 0, 0, 16'h0000, 1, S_LOAD, 16'h1236, C_LOAD, 16'h5555);
        tbl[24] = mks(1, 0, 0, 0, 16'h0000, 1, S_IDLE, 16'h5555, C_IDLE, 16'h0000);

        for (int i = 0; i < 25; i++) apply(tbl[i], i);

        // Terminal count: one instance wraps to 0, the other halts at all-ones
        apply(mks(1, 1, 0, 1, 16'hFFFE, 1, S_IDLE, 16'h5555, C_IDLE, 16'h0000), 100);
        apply(mks(1, 1, 0, 0, 16'h0000, 1, S_LOAD, 16'h5555, C_LOAD, 16'hFFFE), 101);
        apply(mks(1, 1, 0, 0, 16'h0000, 1, S_RUN,  16'hFFFE, C_RUN,  16'h0000), 102);
        apply(mk(1, 1, 0, 0, 16'h0000, 1, S_RUN, 16'hFFFF, C_RUN,
                 S_RUN, 16'hFFFF, C_RUNH, 16'h0000), 103);
        for (int i = 0; i < 10; i++)
            apply(mk(1, 1, 0, 0, 16'h0000, 1, S_RUN, 16'(i), C_RUN,
                     S_HALT, 16'hFFFF, C_HALT, 16'h0000), 104 + i);
        apply(mk(1, 1, 0, 1, 16'h0100, 1, S_RUN, 16'h000A, C_RUNH,
                 S_HALT, 16'hFFFF, C_HALT, 16'h0000), 114);
        apply(mk(1, 1, 0, 0, 16'h0000, 1, S_LOAD, 16'h000A, C_LOAD,
                 S_LOAD, 16'hFFFF, C_LOAD, 16'h0100), 115);
        apply(mks(1, 1, 0, 0, 16'h0000, 1, S_RUN, 16'h0100, C_RUN, 16'h0000), 116);

        // Reset asserted during LOAD: load aborted, chain cleared, INIT replayed
        apply(mks(1, 1, 0, 1, 16'hABCD, 1, S_RUN,  16'h0101, C_RUNH, 16'h0000), 200);
        apply(mks(0, 0, 0, 0, 16'hABCD, 1, S_LOAD, 16'h0101, C_RST,  16'h0000), 201);
        apply(mks(1, 0, 0, 0, 16'h0000, 1, S_INIT, 16'h0000, C_RST,  16'h0000), 202);
        apply(mks(1, 0, 0, 0, 16'h0000, 1, S_INIT, 16'h0000, C_RST,  16'h0000), 203);
        apply(mks(1, 0, 0, 0, 16'h0000, 1, S_IDLE, 16'h0000, C_IDLE, 16'h0000), 204);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_chain_sequencer.md
Name: pc_chain_sequencer

Overview:
- Control sequencer for a WIDTH-bit program counter built from cascaded 4-bit synchronous loadable counter slices.
- Drives the chain's master-reset, parallel-enable, count-enable and load-data lines.
- Arbitrates jump (load) requests against free-running increment, and optionally halts at terminal count instead of wrapping.
- Sits between the CPU control unit and the PC counter chain.

Parameters:
WIDTH, 16, counter chain width in bits; must be a multiple of 4
RST_CYCLES, 2, number of cycles the chain reset is held after _MR is released; must be ≥1
WRAP, 1, 1 = wrap from all-ones to 0; 0 = halt at all-ones

Ports:
CP  input  1  clock, rising edge
_MR  input  1  reset, synchronous, active-low
run  input  1  level; enables counting
stall  input  1  level; freezes count while in RUN
jmp_req  input  1  jump request; held by requester until jmp_ack
jmp_addr  input  WIDTH  jump target; sampled on the edge that accepts jmp_req
jmp_ack  output  1  high for exactly the LOAD cycle
cnt_MR_n  output  1  to chain _MR
cnt_PE_n  output  1  to chain _PE, all slices
cnt_CEP  output  1  to chain CEP, all slices
cnt_CET  output  1  to slice-0 CET; upper slices ripple via TC
cnt_D  output  WIDTH  to chain D
cnt_Q  input  WIDTH  chain Q (current PC)
cnt_TC  input  1  TC of most-significant slice
halted  output  1  high in HALT
state  output  3  INIT=0, IDLE=1, RUN=2, LOAD=3, HALT=4

Behaviour:
- Clock and reset: one clock CP; synchronous active-low reset _MR, sampled on posedge CP only.
- Registered: state, init counter, jump-address register (jreg).
- Combinational from state and inputs, so the chain acts on the same edge: all cnt_* outputs, jmp_ack, halted.
- _MR low at posedge:
  - state←INIT, init counter←0, jreg←0.
  - While _MR is low: cnt_MR_n=0 regardless of state; cnt_PE_n=1, cnt_CEP=0, cnt_CET=0, cnt_D=0, jmp_ack=0, halted=0.
- INIT:
  - cnt_MR_n=0, other controls inactive.
  - Stays RST_CYCLES cycles after _MR goes high, then →IDLE.
  - jmp_req and run are ignored.
- IDLE:
  - cnt_MR_n=1, cnt_PE_n=1, CEP=CET=0.
  - jmp_req=1 → capture jmp_addr, →LOAD.
  - Otherwise run=1 → RUN.
- RUN:
  - cnt_CET=1; cnt_CEP = run & ~stall & ~jmp_req & ~(WRAP==0 & cnt_TC).
  - Next state, in priority order:
    - jmp_req → capture jmp_addr, →LOAD; no increment that edge.
    - WRAP==0 & cnt_TC → HALT; no increment, so PC stays all-ones.
    - ~run → IDLE; no increment.
    - else stay in RUN.
  - stall=1: PC holds, state stays RUN.
  - WRAP==1: all-ones increments to 0 normally.
- LOAD:
  - cnt_PE_n=0, cnt_D=jreg, CEP=CET=0, jmp_ack=1.
  - The chain loads jreg on the exiting edge.
  - Exit: →RUN if run=1, else →IDLE.
  - Requester must drop jmp_req at the edge ending ack; a req still high in the next cycle is a new request.
- HALT:
  - halted=1, all controls inactive.
  - Exits only via jmp_req (capture, →LOAD) or _MR low; run is ignored.
- Latency:
  - Increment: PC changes on the same edge that the enabling inputs are sampled.
  - Jump: req accepted at edge N; ack high N..N+1; cnt_Q=addr after edge N+1 (2-edge latency).
- jmp_addr changing after acceptance has no effect (jreg holds).
- Reset mid-LOAD: load aborted, chain cleared, no ack beyond that cycle.
- Outputs never X after the first reset edge; state encodings 5–7 are unreachable and decode to INIT.

Test Plan:
- Reset then run: _MR low 1 cycle, release, run=1 → cnt_MR_n low for the reset cycle plus 2 INIT cycles, state INIT→IDLE→RUN; cnt_Q counts 0,1,2,… one per edge.
- Stall: in RUN at PC=0x0005, stall=1 for 3 cycles → PC holds 0x0005, CEP=0, state=RUN; on release, next edge gives 0x0006.
- Jump: at PC=0x0010, jmp_req=1 with addr 0x1234 → next cycle state=LOAD, jmp_ack=1, PE_n=0, PC still 0x0010; following edge PC=0x1234, then 0x1235.
- Wrap: WRAP=1, jump to 0xFFFE, run → PC 0xFFFF then 0x0000, cnt_TC high for the 0xFFFF cycle.
- Halt: WRAP=0, jump to 0xFFFE → PC reaches 0xFFFF, state=HALT, halted=1, PC stays 0xFFFF for 10 cycles with run=1; jmp_req to 0x0100 → LOAD, then PC=0x0100 and RUN.
- Reset mid-operation: assert _MR during LOAD with addr 0xABCD → PC=0x0000, jmp_ack low from the reset edge, state INIT, no load of 0xABCD.
